mc_alu: RTL and testbench
=========================

MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; legal values are 8, 16, 32 and 64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width in bits.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 in_valid  input  1: operand/opcode presented.
REQ-006 in_ready  output  1: block can accept an operation.
REQ-007 r1  input  WIDTH: operand A.
REQ-008 r2  input  WIDTH: operand B.
REQ-009 control  input  4: opcode.
REQ-010 out_valid  output  1: result available.
REQ-011 out_ready  input  1: consumer accepts result.
REQ-012 result  output  WIDTH: operation result.
REQ-013 bcond  output  1: branch condition for opcodes 8 and 9; 0 for all other opcodes.
REQ-014 illegal  output  1: set when the completed opcode is reserved.

Function
REQ-015 Opcodes SHALL be as follows:
- 0 ADD; 1 AND; 2 OR; 3 SLL; 4 SLT (signed); 5 SRL; 6 SUB; 7 XOR.
- 8 BEQ; 9 BNE; 10 MUL (low WIDTH bits); 11 DIVU; 12 REMU; 13 SRA; 14 SLTU.
- 15 reserved.
REQ-016 Arithmetic SHALL wrap modulo 2^WIDTH; shifts SHALL use r2[SHW-1:0] only.
REQ-017 SLT/SLTU SHALL return 1 or 0, zero-extended to WIDTH.
REQ-018 BEQ/BNE SHALL set result=0 and bcond=(r1==r2) / (r1!=r2).
REQ-019 The block SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-020 in_ready SHALL be 1 only in IDLE; an operation is accepted on a cycle with in_valid && in_ready.
REQ-021 Single-cycle ops (0-9, 13-15) SHALL go IDLE->DONE; out_valid SHALL assert on the cycle after acceptance.
REQ-022 MUL SHALL use iterative shift-add, DIVU/REMU SHALL use restoring division, each one bit per cycle:
- path IDLE->BUSY, with BUSY held for exactly WIDTH cycles, then ->DONE;
- out_valid SHALL assert WIDTH+1 cycles after acceptance.
REQ-023 Divide by zero SHALL complete as a single-cycle op: DIVU gives all ones, REMU gives r1.
REQ-024 Operands and opcode SHALL be latched at acceptance; input changes during BUSY/DONE SHALL have no effect.
REQ-025 In DONE, result/bcond/illegal SHALL be held stable while out_ready=0.
REQ-026 When out_valid && out_ready, the FSM SHALL go DONE->IDLE; the earliest next accept is the following cycle.
REQ-027 Reserved opcode 15 SHALL give result=0 and illegal=1 for that transaction only.
REQ-028 result, bcond and illegal SHALL be 0 whenever out_valid=0.

Reset
REQ-029 rst=1 at any rising edge SHALL force IDLE and set out_valid=0, result=0, bcond=0, illegal=0, in_ready=1 on the next cycle.
REQ-030 Reset mid-BUSY or mid-DONE SHALL discard the operation with no result emitted.
REQ-031 Iteration counter and partial registers SHALL clear on reset.
REQ-032 in_valid SHALL be ignored on cycles where rst=1.

Verification (WIDTH=32)
REQ-033 ADD: r1=5, r2=7, out_ready=1 -> result=12 with out_valid on cycle accept+1; SUB 5-7 -> 0xFFFFFFFE.
REQ-034 Compare: r1=0xFFFFFFFF, r2=1 -> SLT=1, SLTU=0; SRA by 4 -> 0xFFFFFFFF; SRL by 36 -> 0x0FFFFFFF (uses amount 4); BEQ 9,9 -> bcond=1.
REQ-035 MUL: 12345*678 -> 8369910 with out_valid exactly 33 cycles after accept and in_ready=0 throughout; DIVU 100/7 -> 14; REMU -> 2.
REQ-036 Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, each at latency 1.
REQ-037 Backpressure: hold out_ready=0 for 3 cycles after ADD 1+2 while r1/r2 toggle -> result stays 3, in_ready stays 0, and the next accept occurs one cycle after out_ready=1.
REQ-038 Reset: assert rst on cycle 10 of a MUL -> next cycle out_valid=0, in_ready=1, with no stale result following a subsequent ADD.

Source files
------------

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle ops complete in one step, MUL/DIVU/REMU
// iterate one bit per cycle through a shared accumulator datapath.
module mc_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [3:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             bcond,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_BNE  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIVU = 4'd11;
  localparam logic [3:0] OP_REMU = 4'd12;
  localparam logic [3:0] OP_SRA  = 4'd13;
  localparam logic [3:0] OP_SLTU = 4'd14;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bc_q, bc_d;
  logic             ill_q, ill_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_bc;
  logic             sc_ill;
  logic             div0;
  logic             multi;

  always_comb begin
    shamt  = r2[SHW-1:0];
    sc_res = '0;
    sc_bc  = 1'b0;
    sc_ill = 1'b0;
    div0   = (r2 == '0);
    case (control)
      OP_ADD:  sc_res = r1 + r2;
      OP_AND:  sc_res = r1 & r2;
      OP_OR:   sc_res = r1 | r2;
      OP_SLL:  sc_res = r1 << shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}},
                         $signed(r1) < $signed(r2)};
      OP_SRL:  sc_res = r1 >> shamt;
      OP_SUB:  sc_res = r1 - r2;
      OP_XOR:  sc_res = r1 ^ r2;
      OP_BEQ:  sc_bc  = (r1 == r2);
      OP_BNE:  sc_bc  = (r1 != r2);
      OP_MUL:  sc_res = '0;
      // Divide-by-zero short-cuts; non-zero divisors take the BUSY path
      OP_DIVU: sc_res = '1;
      OP_REMU: sc_res = r1;
      OP_SRA:  sc_res = $unsigned($signed(r1) >>> shamt);
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, r1 < r2};
      default: sc_ill = 1'b1;
    endcase
    multi = (control == OP_MUL) ||
            (((control == OP_DIVU) ||
              (control == OP_REMU)) && !div0);
  end

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] div_quo;

  // MUL: acc=product, x=multiplicand, y=multiplier
  // DIV: acc=remainder, x=dividend/quotient, y=divisor
  always_comb begin
    mul_acc  = y_q[0] ? (acc_q + x_q) : acc_q;
    div_sh   = {acc_q, x_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, y_q});
    div_diff = div_sh - {1'b0, y_q};
    div_rem  = div_ge ? div_diff[WIDTH-1:0]
                      : div_sh[WIDTH-1:0];
    div_quo  = {x_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    bc_d    = bc_q;
    ill_d   = ill_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = control;
          if (multi) begin
            state_d = BUSY;
            acc_d   = '0;
            x_d     = r1;
            y_d     = r2;
            cnt_d   = '0;
          end else begin
            state_d = DONE;
            res_d   = sc_res;
            bc_d    = sc_bc;
            ill_d   = sc_ill;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == OP_MUL) begin
          acc_d = mul_acc;
          x_d   = x_q << 1;
          y_d   = y_q >> 1;
        end else begin
          acc_d = div_rem;
          x_d   = div_quo;
        end
        if (cnt_q == LAST) begin
          state_d = DONE;
          bc_d    = 1'b0;
          ill_d   = 1'b0;
          unique case (1'b1)
            (op_q == OP_MUL):  res_d = mul_acc;
            (op_q == OP_DIVU): res_d = div_quo;
            default:           res_d = div_rem;
          endcase
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          res_d   = '0;
          bc_d    = 1'b0;
          ill_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      bc_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      bc_q    <= bc_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = out_valid ? res_q : '0;
  assign bcond     = out_valid & bc_q;
  assign illegal   = out_valid & ill_q;

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu: stimulus pushes expected results,
// an independent monitor pops and compares on every output.
module tb_mc_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic [3:0]   control;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         bcond;
  logic         illegal;

  mc_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r1        (r1),
    .r2        (r2),
    .control   (control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .bcond     (bcond),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         bc;
    logic         ill;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   or_mode = 2;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    int   sh;
    sh    = int'(b % W);
    e.res = '0;
    e.bc  = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    e.acc = 0;
    case (op)
      4'd0:  e.res = a + b;
      4'd1:  e.res = a & b;
      4'd2:  e.res = a | b;
      4'd3:  e.res = a << sh;
      4'd4:  e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd5:  e.res = a >> sh;
      4'd6:  e.res = a - b;
      4'd7:  e.res = a ^ b;
      4'd8:  e.bc  = (a == b);
      4'd9:  e.bc  = (a != b);
      4'd10: begin
        e.res = a * b;
        e.lat = W + 1;
      end
      4'd11: begin
        e.res = (b == 0) ? '1 : a / b;
        e.lat = (b == 0) ? 1 : W + 1;
      end
      4'd12: begin
        e.res = (b == 0) ? a : a % b;
        e.lat = (b == 0) ? 1 : W + 1;
      end
      4'd13: e.res = $unsigned($signed(a) >>> sh);
      4'd14: e.res = (a < b) ? 1 : 0;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // out_ready driver: 0 random, 1 held low, 2 held high
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 9) < 7);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor
  initial begin
    exp_t cur;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else begin
        if (seen || (q.size() > 0 && cyc >= q[0].acc))
          chk("in_ready_busy", 64'(in_ready), 64'd0);
        if (!out_valid) begin
          chk("idle_zero", {result, bcond, illegal}, 64'd0);
        end else if (!seen) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected none",
                     result);
          end else begin
            cur = q.pop_front();
            chk("result", 64'(result), 64'(cur.res));
            chk("bcond", 64'(bcond), 64'(cur.bc));
            chk("illegal", 64'(illegal), 64'(cur.ill));
            chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
            seen = 1'b1;
          end
        end else begin
          chk("hold", {result, bcond, illegal},
              {cur.res, cur.bc, cur.ill});
        end
        if (out_valid && out_ready) seen = 1'b0;
      end
    end
  end

  task automatic issue(input logic [3:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t e;
    bit   ok;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    control  = op;
    r1       = a;
    r2       = b;
    ok       = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      e     = model(op, a, b);
      e.acc = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      control  = 4'($urandom);
      r1       = $urandom;
      r2       = $urandom;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (q.size() == 0 && !seen) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    control  = '0;
    r1       = '0;
    r2       = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_outputs", {result, bcond, illegal}, 64'd0);

    or_mode = 2;
    issue(4'd0, 5, 7);
    issue(4'd6, 5, 7);
    issue(4'd4, 32'hFFFF_FFFF, 1);
    issue(4'd14, 32'hFFFF_FFFF, 1);
    issue(4'd13, 32'hFFFF_FFFF, 4);
    issue(4'd5, 32'hFFFF_FFFF, 36);
    issue(4'd8, 9, 9);
    issue(4'd9, 9, 9);
    issue(4'd10, 12345, 678);
    issue(4'd11, 100, 7);
    issue(4'd12, 100, 7);
    issue(4'd11, 5, 0);
    issue(4'd12, 5, 0);
    issue(4'd15, 3, 4);
    issue(4'd0, 1, 1);
    drain();

    // Backpressure with inputs toggling while DONE
    or_mode = 1;
    issue(4'd0, 1, 2);
    repeat (3) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      control  = 4'd7;
      r1       = $urandom;
      r2       = $urandom;
    end
    @(negedge clk);
    chk("bp_result", 64'(result), 64'd3);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    or_mode  = 2;
    @(negedge clk);
    chk("bp_still_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    chk("bp_ready_after", 64'(in_ready), 64'd1);
    issue(4'd0, 3, 4);
    drain();

    // Reset mid-MUL, with in_valid asserted alongside reset
    issue(4'd10, 12345, 678);
    repeat (8) @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b1;
    control  = 4'd0;
    r1       = 1;
    r2       = 1;
    q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_result", 64'(result), 64'd0);
    issue(4'd0, 2, 2);
    drain();

    or_mode = 0;
    for (int i = 0; i < 250; i++)
      issue(4'($urandom_range(0, 15)), pick(), pick());
    or_mode = 2;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
